// File: rtl/ll_refcount_mgr.sv
// rtl/ll_refcount_mgr.sv - per-page reference counter that returns pages to the free list at zero
module ll_refcount_mgr #(
  parameter int pg_asz    = 8,
  parameter int refsz     = 3,
  parameter int num_ports = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              refup_srdy,
  output logic              refup_drdy,
  input  logic [pg_asz-1:0] refup_page,
  input  logic [refsz-1:0]  refup_count,
  input  logic              dec_srdy,
  output logic              dec_drdy,
  input  logic [pg_asz-1:0] dec_page,
  output logic              free_srdy,
  input  logic              free_drdy,
  output logic [pg_asz-1:0] free_page,
  output logic [pg_asz:0]   pages_in_use,
  output logic              err_overwrite,
  output logic              err_underflow
);

  localparam int num_pages = 1 << pg_asz;
  localparam logic [pg_asz:0] piu_max = {1'b1, {pg_asz{1'b0}}};

  logic [refsz-1:0] cnt [num_pages];
  logic             toggle;

  logic             can_issue;
  logic             grant_refup;
  logic             refup_acc;
  logic             dec_acc;
  logic [refsz-1:0] old_r;
  logic [refsz-1:0] old_d;
  logic             load_free;
  logic [pg_asz-1:0] load_page;

  assign can_issue   = !free_srdy || free_drdy;
  // toggle remembers who won the last contended cycle; the other side wins the next one
  assign grant_refup = (refup_srdy && dec_srdy) ? !toggle : refup_srdy;
  assign refup_drdy  = can_issue && refup_srdy && grant_refup;
  assign dec_drdy    = can_issue && dec_srdy && !grant_refup;
  assign refup_acc   = refup_drdy;
  assign dec_acc     = dec_drdy;
  assign old_r       = cnt[refup_page];
  assign old_d       = cnt[dec_page];

  always_comb begin
    load_free = 1'b0;
    load_page = '0;
    if (refup_acc && refup_count == '0) begin
      load_free = 1'b1;
      load_page = refup_page;
    end else if (dec_acc && old_d == refsz'(1)) begin
      load_free = 1'b1;
      load_page = dec_page;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < num_pages; i++) cnt[i] <= '0;
      toggle        <= 1'b0;
      free_srdy     <= 1'b0;
      free_page     <= '0;
      pages_in_use  <= '0;
      err_overwrite <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (refup_srdy && dec_srdy && can_issue)
        toggle <= grant_refup;

      if (refup_acc) begin
        if (refup_count != '0)
          cnt[refup_page] <= refup_count;
        if (old_r != '0)
          err_overwrite <= 1'b1;
        else if (refup_count != '0 && pages_in_use != piu_max)
          pages_in_use <= pages_in_use + 1'b1;
      end

      if (dec_acc) begin
        if (old_d == '0) begin
          err_underflow <= 1'b1;
        end else begin
          cnt[dec_page] <= old_d - 1'b1;
          if (old_d == refsz'(1) && pages_in_use != '0)
            pages_in_use <= pages_in_use - 1'b1;
        end
      end

      if (load_free) begin
        free_srdy <= 1'b1;
        free_page <= load_page;
      end else if (free_drdy) begin
        free_srdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ll_refcount_mgr.sv
// tb/tb_ll_refcount_mgr.sv - directed self-checking bench for ll_refcount_mgr
module tb_ll_refcount_mgr;

  logic       clk = 1'b0;
  logic       reset;
  logic       refup_srdy, refup_drdy;
  logic [7:0] refup_page;
  logic [2:0] refup_count;
  logic       dec_srdy, dec_drdy;
  logic [7:0] dec_page;
  logic       free_srdy, free_drdy;
  logic [7:0] free_page;
  logic [8:0] pages_in_use;
  logic       err_overwrite, err_underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ll_refcount_mgr #(.pg_asz(8), .refsz(3), .num_ports(4)) dut (
    .clk(clk), .reset(reset),
    .refup_srdy(refup_srdy), .refup_drdy(refup_drdy),
    .refup_page(refup_page), .refup_count(refup_count),
    .dec_srdy(dec_srdy), .dec_drdy(dec_drdy), .dec_page(dec_page),
    .free_srdy(free_srdy), .free_drdy(free_drdy), .free_page(free_page),
    .pages_in_use(pages_in_use),
    .err_overwrite(err_overwrite), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    refup_srdy = 0; refup_page = 0; refup_count = 0;
    dec_srdy = 0; dec_page = 0; free_drdy = 1;
    #3;
    chk("rst_free_srdy", free_srdy, 0);
    chk("rst_free_page", free_page, 0);
    chk("rst_piu", pages_in_use, 0);
    chk("rst_err_ov", err_overwrite, 0);
    chk("rst_err_uf", err_underflow, 0);
    tick; tick;
    reset = 1'b0;
    tick;

    // refup 0x12 x3, then three decrements
    refup_srdy = 1; refup_page = 8'h12; refup_count = 3;
    #1 chk("t1_refup_drdy", refup_drdy, 1);
    tick;
    refup_srdy = 0;
    chk("t1_piu1", pages_in_use, 1);
    dec_srdy = 1; dec_page = 8'h12;
    #1 chk("t1_dec_drdy", dec_drdy, 1);
    tick;
    chk("t1_nofree1", free_srdy, 0);
    tick;
    chk("t1_nofree2", free_srdy, 0);
    chk("t1_piu_still1", pages_in_use, 1);
    tick;
    dec_srdy = 0;
    chk("t1_free", free_srdy, 1);
    chk("t1_free_page", free_page, 8'h12);
    chk("t1_piu0", pages_in_use, 0);
    tick;
    chk("t1_free_clear", free_srdy, 0);

    // refup with zero destinations frees immediately
    refup_srdy = 1; refup_page = 8'h05; refup_count = 0;
    #1 chk("t2_refup_drdy", refup_drdy, 1);
    tick;
    refup_srdy = 0;
    chk("t2_free", free_srdy, 1);
    chk("t2_free_page", free_page, 8'h05);
    chk("t2_piu0", pages_in_use, 0);
    tick;

    // backpressure from the free list blocks both request sides
    free_drdy = 0;
    refup_srdy = 1; refup_page = 8'h20; refup_count = 0;
    tick;
    chk("t3_free_pend", free_srdy, 1);
    refup_page = 8'h21; refup_count = 1;
    dec_srdy = 1; dec_page = 8'h30;
    #1;
    chk("t3_bp_refup", refup_drdy, 0);
    chk("t3_bp_dec", dec_drdy, 0);
    tick;
    chk("t3_bp_hold", free_srdy, 1);
    chk("t3_bp_page", free_page, 8'h20);
    chk("t3_bp_refup2", refup_drdy, 0);
    free_drdy = 1;
    #1;
    chk("t3_rel_refup", refup_drdy, 1);
    chk("t3_rel_dec", dec_drdy, 0);
    tick;
    chk("t3_free_done", free_srdy, 0);
    chk("t3_piu1", pages_in_use, 1);

    // continuous contention alternates grants
    dec_page = 8'h21;
    #1;
    chk("t4_a_dec", dec_drdy, 1);
    chk("t4_a_refup", refup_drdy, 0);
    tick;
    chk("t4_a_free", free_srdy, 1);
    chk("t4_a_page", free_page, 8'h21);
    chk("t4_a_piu", pages_in_use, 0);
    refup_page = 8'h60; refup_count = 2;
    #1;
    chk("t4_b_refup", refup_drdy, 1);
    chk("t4_b_dec", dec_drdy, 0);
    tick;
    chk("t4_b_free_clr", free_srdy, 0);
    chk("t4_b_piu", pages_in_use, 1);
    dec_page = 8'h60;
    #1 chk("t4_c_dec", dec_drdy, 1);
    tick;
    chk("t4_c_nofree", free_srdy, 0);
    refup_page = 8'h61; refup_count = 1;
    #1 chk("t4_d_refup", refup_drdy, 1);
    tick;
    refup_srdy = 0; dec_srdy = 0;
    chk("t4_d_piu", pages_in_use, 2);

    // 0x05 count was left at zero by the zero-destination refup
    refup_srdy = 1; refup_page = 8'h05; refup_count = 1;
    tick;
    refup_srdy = 0;
    chk("t2b_no_ov", err_overwrite, 0);
    chk("t2b_piu3", pages_in_use, 3);
    dec_srdy = 1; dec_page = 8'h05;
    tick;
    chk("t2b_free_page", free_page, 8'h05);
    chk("t2b_piu2", pages_in_use, 2);

    // underflow and overwrite errors
    dec_page = 8'h40;
    tick;
    dec_srdy = 0;
    chk("t5_uf", err_underflow, 1);
    chk("t5_uf_nofree", free_srdy, 0);
    chk("t5_uf_piu", pages_in_use, 2);
    tick;
    chk("t5_uf_sticky", err_underflow, 1);
    refup_srdy = 1; refup_page = 8'h41; refup_count = 2;
    tick;
    chk("t5_ov_first", err_overwrite, 0);
    tick;
    refup_srdy = 0;
    chk("t5_ov", err_overwrite, 1);
    chk("t5_ov_piu", pages_in_use, 3);
    dec_srdy = 1; dec_page = 8'h41;
    tick;
    chk("t5_cnt2_nofree", free_srdy, 0);
    tick;
    dec_srdy = 0;
    chk("t5_cnt2_free", free_srdy, 1);
    chk("t5_cnt2_page", free_page, 8'h41);
    chk("t5_cnt2_piu", pages_in_use, 2);

    // asynchronous reset with a free pending
    free_drdy = 0;
    #2 reset = 1'b1;
    #1;
    chk("t6_free_srdy", free_srdy, 0);
    chk("t6_free_page", free_page, 0);
    chk("t6_piu", pages_in_use, 0);
    chk("t6_err_ov", err_overwrite, 0);
    chk("t6_err_uf", err_underflow, 0);
    tick;
    reset = 1'b0;
    free_drdy = 1;
    dec_srdy = 1; dec_page = 8'h60;
    tick;
    dec_srdy = 0;
    chk("t6_uf_after", err_underflow, 1);
    chk("t6_nofree", free_srdy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ll_refcount_mgr.md
Name: ll_refcount_mgr

Overview:
- Receiving end of the FIB lookup's reference-update channel (refup_page/refup_count).
- Holds a per-page reference count for every linked-list page.
- Accepts per-port "page done" decrements from the output side and emits a page-free request to the free-list when a count reaches zero.
- Sits between the FIB lookup, the port output queues and the linked-list free manager.

Parameters:
- pg_asz, 8, page address width; number of pages = 2**pg_asz
- refsz, 3, reference count width; must hold num_ports
- num_ports, 4, number of output ports; refup_count values above num_ports are errors

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- refup_srdy  input  1  reference-update valid
- refup_drdy  output  1  reference-update accepted
- refup_page  input  pg_asz  page receiving a new count
- refup_count  input  refsz  number of destinations referencing the page
- dec_srdy  input  1  decrement request valid (already arbitrated across ports upstream)
- dec_drdy  output  1  decrement accepted
- dec_page  input  pg_asz  page one port has finished with
- free_srdy  output  1  page-free request valid (registered)
- free_drdy  input  1  free-list ready
- free_page  output  pg_asz  page to return to the free list (registered)
- pages_in_use  output  pg_asz+1  count of pages with nonzero refcount (registered)
- err_overwrite  output  1  sticky: refup to a page whose count was nonzero
- err_underflow  output  1  sticky: decrement of a page whose count was zero

Behaviour:
- Reset (asynchronous, active-high): all counts = 0; free_srdy = 0; free_page = 0; pages_in_use = 0; both error flags = 0; arbitration toggle = 0 (refup favoured first).
- Storage: flop array of 2**pg_asz entries × refsz. Read-modify-write completes in one cycle. No init sweep is needed.
- Free output: one-entry holding register.
  - can_issue = !free_srdy || free_drdy.
  - free_srdy clears on free_drdy unless a new free is loaded in the same cycle.
- Arbitration:
  - Only one of refup and dec is accepted per cycle, and only while can_issue.
  - If only one srdy is high, that side is granted.
  - If both are high, the grant goes to the side not granted last contended cycle (toggle flop, updated only on contention).
  - drdy is combinational: refup_drdy = can_issue && refup_srdy && grant_refup. dec_drdy likewise.
- Refup accept, cycle N:
  - count[page] <= refup_count, visible at N+1.
  - If the old count != 0, set err_overwrite and do not change pages_in_use.
  - Else if refup_count != 0, pages_in_use += 1.
  - If refup_count == 0 (packet had no destinations), no store; free_srdy = 1 and free_page = page at N+1.
- Dec accept, cycle N:
  - If count == 0: set err_underflow; no state change; no free.
  - If count == 1: count <= 0; pages_in_use -= 1; free_srdy = 1 and free_page = dec_page at N+1.
  - Otherwise: count <= count - 1.
- A refup followed next cycle by a dec to the same page sees the updated count (no hazard; single-cycle RMW).
- Free backpressure: while free_srdy && !free_drdy, both refup_drdy and dec_drdy are 0. Requests must hold their data until accepted.
- pages_in_use never wraps. Maximum value is 2**pg_asz.
- Error flags are cleared only by reset.
- Reset mid-operation: a pending free is dropped, and all counts clear immediately (asynchronous).

Test Plan:
- Refup page 0x12 count 3, then three decs of 0x12 -> no free after the first two; free_srdy=1, free_page=0x12 one cycle after the third accept; pages_in_use goes 1 then 0.
- Refup page 0x05 count 0 -> refup accepted; free_page=0x05 next cycle; pages_in_use stays 0; count unchanged.
- Hold free_drdy=0 with a free pending, present refup and dec -> both drdy stay 0; raise free_drdy -> free handshake completes in that cycle and the refup is accepted in the same cycle.
- refup_srdy and dec_srdy held high continuously (different pages, free_drdy=1) -> grants alternate refup, dec, refup, dec; neither side starves.
- Dec page 0x40 with count 0 -> err_underflow=1 and stays set; no free. Refup 0x41 count 2 twice -> err_overwrite=1; pages_in_use=1; count=2.
- Assert reset asynchronously mid-stream with a free pending -> free_srdy, pages_in_use and all counts go to 0 immediately without a clock edge; next dec to any page flags underflow.
